// File: rtl/sync_debouncer_pkg.sv
// Shared state encodings and helpers for the per-bit debounce filter.
// Other CDC-side blocks import the same encodings.
package sync_debouncer_pkg;

    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'b00,
        ST_CHK_HI    = 2'b01,
        ST_STABLE_HI = 2'b11,
        ST_CHK_LO    = 2'b10
    } db_state_e;

    function automatic logic is_check(input db_state_e s);
        return (s == ST_CHK_HI) || (s == ST_CHK_LO);
    endfunction

    // A bit that is checking a candidate low level still reports high.
    function automatic logic level_of(input db_state_e s);
        return (s == ST_STABLE_HI) || (s == ST_CHK_LO);
    endfunction

endpackage

// File: rtl/sync_debouncer_debounce_bit.sv
// Single-bit debounce filter: four-state FSM with a saturating stability counter
// and registered level/edge outputs.
module debounce_bit
    import sync_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_WIDTH       = 8
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic sample_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o,
    output logic chk_next_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    db_state_e              state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_STABLE_LO;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    // With en_i low nothing moves, so the edge detectors below see no transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (en_i) begin
            unique case (state_q)
                ST_STABLE_LO: begin
                    if (sample_i) begin
                        state_d = ST_CHK_HI;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d   = '0;
                    end
                end
                ST_CHK_HI: begin
                    if (!sample_i) begin
                        state_d = ST_STABLE_LO;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_STABLE_HI;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
                ST_STABLE_HI: begin
                    if (!sample_i) begin
                        state_d = ST_CHK_LO;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d   = '0;
                    end
                end
                ST_CHK_LO: begin
                    if (sample_i) begin
                        state_d = ST_STABLE_HI;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_STABLE_LO;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_STABLE_LO;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        stable_d   = level_of(state_d);
        rise_d     = (state_q == ST_CHK_HI) && (state_d == ST_STABLE_HI);
        fall_d     = (state_q == ST_CHK_LO) && (state_d == ST_STABLE_LO);
        chk_next_o = is_check(state_d);
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: rtl/sync_debouncer.sv
// Multi-bit debouncer for already-synchronized inputs: one independent filter
// per bit plus a registered aggregate busy flag.
module sync_debouncer
    import sync_debouncer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_WIDTH       = 8,
    parameter int          DLY             = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] data_synced_i,
    output logic [DATA_WIDTH-1:0] data_stable_o,
    output logic [DATA_WIDTH-1:0] rise_o,
    output logic [DATA_WIDTH-1:0] fall_o,
    output logic                  busy_o
);

    if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > ((1 << CNT_WIDTH) - 1))) begin : g_bad_cycles
        $fatal(1, "sync_debouncer: DEBOUNCE_CYCLES=%0d outside 2..2**CNT_WIDTH-1", DEBOUNCE_CYCLES);
    end
    if (DLY < 0) begin : g_bad_dly
        $fatal(1, "sync_debouncer: DLY must be non-negative");
    end

    logic [DATA_WIDTH-1:0] stable_w, rise_w, fall_w, chk_next_w;
    logic                  busy_q, busy_d;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_WIDTH       (CNT_WIDTH)
        ) u_bit (
            .clk_i      (clk_i),
            .rst_n_i    (rst_n_i),
            .en_i       (en_i),
            .sample_i   (data_synced_i[i]),
            .stable_o   (stable_w[i]),
            .rise_o     (rise_w[i]),
            .fall_o     (fall_w[i]),
            .chk_next_o (chk_next_w[i])
        );
    end

    // Built from next-state so busy_o lines up with the bits' registered state.
    always_comb begin
        busy_d = |chk_next_w;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign data_stable_o = stable_w;
    assign rise_o        = rise_w;
    assign fall_o        = fall_w;
    assign busy_o        = busy_q;

endmodule
